// File: rtl/soc_pkg.sv
// Shared SoC definitions: UART register offsets, STATUS bit positions and
// the transmitter state encoding.
package soc_pkg;

  // Register offsets, decoded from addr[3:2].
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  // STATUS register bit positions.
  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERFLOW = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers. A push to a full FIFO is only
// taken when a pop frees a slot in the same cycle.
module uart_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; wrap-around is the natural overflow of the counters.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; the pointers alone decide which entries
  // are valid, so resetting the data would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register file, transmit FIFO, and the
// bit-timing state machine that serialises FIFO bytes onto tx.
module uart_tx_mmio
  import soc_pkg::*;
#(
  parameter int unsigned CLK_DIV_DEFAULT = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic        rstrb,
  input  logic        wstrb,
  input  logic [31:0] wdata,
  input  logic [1:0]  wsize,
  output logic [31:0] rdata,
  output logic        tx
);

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic        overflow_q, overflow_d;
  logic [31:0] rdata_q, rdata_d;

  logic        wr_en, rd_en, push, pop;
  logic [1:0]  reg_sel;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty, busy;
  logic        unused_bits;

  assign reg_sel     = addr[3:2];
  assign wr_en       = sel & wstrb;
  assign rd_en       = sel & rstrb;
  assign push        = wr_en && (reg_sel == REG_TXDATA);
  assign busy        = (state_q != UART_IDLE);
  assign unused_bits = ^{wsize, addr[1:0], wdata[31:16]};

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (wdata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Register file: divisor and sticky overflow updates, registered read mux.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    div_d      = div_q;
    overflow_d = overflow_q;
    rdata_d    = rdata_q;
    if (wr_en && (reg_sel == REG_DIVISOR))
      div_d = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
    if (wr_en && (reg_sel == REG_STATUS) && wdata[STAT_OVERFLOW])
      overflow_d = 1'b0;
    if (push && fifo_full && !pop)
      overflow_d = 1'b1;
    if (rd_en) begin
      rdata_d = '0;
      case (reg_sel)
        REG_STATUS: begin
          rdata_d[STAT_FULL]     = fifo_full;
          rdata_d[STAT_EMPTY]    = fifo_empty;
          rdata_d[STAT_BUSY]     = busy;
          rdata_d[STAT_OVERFLOW] = overflow_q;
        end
        REG_DIVISOR: rdata_d[15:0] = div_q;
        default: ;
      endcase
    end
  end

  // Transmit FSM: frame start pops the FIFO and latches the divisor, so a
  // divisor write only affects frames that start after it.
  // NOTE: always_comb uses blocking assignments; later statements override
  // the defaults, which is what makes the default-first pattern work.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_lat_d = div_lat_q;
    pop       = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_dout;
          div_lat_d = div_q;
          baud_d    = div_q - 16'd1;
          state_d   = UART_START;
        end
      end
      UART_START: begin
        if (baud_q == 16'd0) begin
          baud_d    = div_lat_q - 16'd1;
          bit_cnt_d = 3'd0;
          state_d   = UART_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      UART_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d    = div_lat_q - 16'd1;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = UART_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      UART_STOP: begin
        if (baud_q == 16'd0) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = fifo_dout;
            div_lat_d = div_q;
            baud_d    = div_q - 16'd1;
            state_d   = UART_START;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // State and register flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= UART_IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      div_q      <= 16'(CLK_DIV_DEFAULT);
      div_lat_q  <= 16'(CLK_DIV_DEFAULT);
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      div_lat_q  <= div_lat_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  // Line level decoded from state; reset forces IDLE and thus tx high at once.
  always_comb begin
    tx = 1'b1;
    if (state_q == UART_START)     tx = 1'b0;
    else if (state_q == UART_DATA) tx = shift_q[0];
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: table of idle register accesses plus
// hand-written multi-cycle sequences checking tx bit timing cycle by cycle.
module tb_uart_tx_mmio;

  localparam logic [3:0] A_TXDATA  = 4'h0;
  localparam logic [3:0] A_STATUS  = 4'h4;
  localparam logic [3:0] A_DIVISOR = 4'h8;
  localparam logic [3:0] A_RESV    = 4'hC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic        rstrb = 1'b0;
  logic        wstrb = 1'b0;
  logic [31:0] wdata = '0;
  logic [1:0]  wsize = 2'd2;
  logic [31:0] rdata;
  logic        tx;

  int n_total = 0;
  int n_pass  = 0;

  uart_tx_mmio #(.CLK_DIV_DEFAULT(16), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sel    (sel),
    .addr   (addr),
    .rstrb  (rstrb),
    .wstrb  (wstrb),
    .wdata  (wdata),
    .wsize  (wsize),
    .rdata  (rdata),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One-cycle bus write, inputs changed on the falling edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wstrb = 1'b0;
  endtask

  // One-cycle bus read; rdata is valid in the cycle after the strobe.
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; rstrb = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b0;
    d = rdata;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Called on the falling edge in the first START cycle; checks every cycle
  // of the 10-bit frame and returns in the first cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input int div, input string name);
    logic exp;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      exp = 1'b0;
      else if (k == 9) exp = 1'b1;
      else             exp = b[k-1];
      for (int c = 0; c < div; c++) begin
        check($sformatf("%s bit%0d cyc%0d", name, k, c), {31'd0, tx}, {31'd0, exp});
        @(negedge clk);
      end
    end
  endtask

  typedef struct {
    bit          is_write;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [7:0]  burst [6];
    logic [31:0] held;
    int          lows;

    vecs[0]  = '{1'b0, A_STATUS,  32'h0,         32'h2};
    vecs[1]  = '{1'b0, A_DIVISOR, 32'h0,         32'd16};
    vecs[2]  = '{1'b1, A_DIVISOR, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, A_DIVISOR, 32'h0,         32'd1};
    vecs[4]  = '{1'b1, A_DIVISOR, 32'hABCD_1234, 32'h0};
    vecs[5]  = '{1'b0, A_DIVISOR, 32'h0,         32'h1234};
    vecs[6]  = '{1'b0, A_TXDATA,  32'h0,         32'h0};
    vecs[7]  = '{1'b1, A_RESV,    32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, A_RESV,    32'h0,         32'h0};
    vecs[9]  = '{1'b1, A_STATUS,  32'hFFFF_FFF7, 32'h0};
    vecs[10] = '{1'b0, A_STATUS,  32'h0,         32'h2};
    vecs[11] = '{1'b0, 4'h6,      32'h0,         32'h2};
    vecs[12] = '{1'b1, A_DIVISOR, 32'd16,        32'h0};
    vecs[13] = '{1'b0, A_DIVISOR, 32'h0,         32'd16};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset rdata", rdata, 32'h0);
    resetn = 1'b1;

    // Idle register accesses.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_write) bus_write(vecs[i].a, vecs[i].d);
      else read_check($sformatf("vec%0d read", i), vecs[i].a, vecs[i].exp);
    end

    // rdata holds when the read is not selected.
    held = rdata;
    @(negedge clk);
    sel = 1'b0; rstrb = 1'b1; addr = A_STATUS;
    @(negedge clk);
    rstrb = 1'b0;
    check("rdata hold", rdata, 32'd16);
    check("rdata hold vs prior", rdata, held);

    // 0x55 at default divisor: tx low two cycles after the write.
    bus_write(A_TXDATA, 32'h55);
    check("tx idle before start", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check_frame(8'h55, 16, "f55");
    read_check("status after 0x55", A_STATUS, 32'h2);

    // Divisor 0 is stored as 1.
    bus_write(A_DIVISOR, 32'h0);
    read_check("divisor 0 reads 1", A_DIVISOR, 32'd1);
    bus_write(A_TXDATA, 32'hA5);
    check("tx idle before A5", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check_frame(8'hA5, 1, "fA5");

    // Burst of six writes at divisor 2: five accepted, sixth overflows.
    bus_write(A_DIVISOR, 32'd2);
    burst = '{8'h11, 8'h22, 8'h4B, 8'h80, 8'hF1, 8'h99};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          sel = 1'b1; wstrb = 1'b1; addr = A_TXDATA; wdata = {24'd0, burst[i]};
        end
        @(negedge clk);
        sel = 1'b0; wstrb = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) check_frame(burst[i], 2, $sformatf("burst%0d", i));
      end
    join
    read_check("status overflow idle", A_STATUS, 32'hA);
    bus_write(A_STATUS, 32'h8);
    read_check("status overflow cleared", A_STATUS, 32'h2);
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("dropped byte never sent", lows, 0);

    // Divisor change mid-frame applies to the next frame only.
    bus_write(A_DIVISOR, 32'd16);
    fork
      begin
        bus_write(A_TXDATA, 32'h3C);
        repeat (20) @(negedge clk);
        read_check("status busy empty", A_STATUS, 32'h6);
        bus_write(A_DIVISOR, 32'd4);
        bus_write(A_TXDATA, 32'hC3);
        read_check("status busy queued", A_STATUS, 32'h4);
      end
      begin
        repeat (3) @(negedge clk);
        check_frame(8'h3C, 16, "f3C");
        check_frame(8'hC3, 4, "fC3");
      end
    join
    read_check("divisor now 4", A_DIVISOR, 32'd4);

    // Reset in the middle of a data bit.
    bus_write(A_TXDATA, 32'h00);
    bus_write(A_TXDATA, 32'hFF);
    repeat (5) @(negedge clk);
    check("tx low in data", {31'd0, tx}, 32'd0);
    resetn = 1'b0;
    #1;
    check("tx high in reset", {31'd0, tx}, 32'd1);
    check("rdata cleared by reset", rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    read_check("status after reset", A_STATUS, 32'h2);
    read_check("divisor after reset", A_DIVISOR, 32'd16);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("no frame after reset", lows, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
